mcl_tx_credit_gate: RTL

- Sits between the host AXI-Lite/stream adapter's transmit output and the manycore link request port.
- Forwards host request packets only when a response slot is guaranteed: an outstanding-request credit is free, and the receive FIFO has space reserved for the response.
- Tracks outstanding requests by snooping the response return path.
- Provides a host fence (drain) handshake and a sticky credit-underflow error flag.

---
 rtl/mcl_tx_credit_gate_if.sv | 42 ++++
 rtl/mcl_tx_credit_gate.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mcl_tx_credit_gate_if.sv
// Handshake bundle between the host transmit adapter, the credit gate and the manycore link.
// slave is the gate's view; master is the view of whatever drives the gate and consumes its outputs.
interface mcl_tx_credit_gate_if #(
  parameter int mcl_width_p       = 128,
  parameter int max_out_credits_p = 16
);
  localparam int cnt_width_lp = $clog2(max_out_credits_p + 1);

  // adapter transmit side
  logic                    req_v_i;
  logic [mcl_width_p-1:0]  req_data_i;
  logic                    req_r_o;

  // manycore link request port
  logic                    link_v_o;
  logic [mcl_width_p-1:0]  link_data_o;
  logic                    link_r_i;

  // snooped response return path and receive FIFO space
  logic                    resp_v_i;
  logic                    resp_r_i;
  logic [cnt_width_lp-1:0] rcv_vacancy_i;

  // fence handshake and status
  logic                    fence_i;
  logic                    fence_busy_o;
  logic                    fence_done_o;
  logic [cnt_width_lp-1:0] out_credits_o;
  logic                    err_underflow_o;

  modport slave (
    input  req_v_i, req_data_i, link_r_i, resp_v_i, resp_r_i, rcv_vacancy_i, fence_i,
    output req_r_o, link_v_o, link_data_o, fence_busy_o, fence_done_o, out_credits_o,
           err_underflow_o
  );

  modport master (
    output req_v_i, req_data_i, link_r_i, resp_v_i, resp_r_i, rcv_vacancy_i, fence_i,
    input  req_r_o, link_v_o, link_data_o, fence_busy_o, fence_done_o, out_credits_o,
           err_underflow_o
  );
endinterface

// File: rtl/mcl_tx_credit_gate.sv
// Credit gate: admits host requests only with a free outstanding credit and reserved receive space.
// Latency 1 cycle through a 2-entry buffer; req_r_o never depends on link_r_i, so link stalls back up via buffer-full.
module mcl_tx_credit_gate #(
  parameter int mcl_width_p       = 128,
  parameter int max_out_credits_p = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  mcl_tx_credit_gate_if.slave   bus_if
);

  localparam int cnt_width_lp = $clog2(max_out_credits_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_credits_p);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    fence_busy_q, fence_busy_d;
  logic                    fence_done_q, fence_done_d;
  logic [cnt_width_lp-1:0] outstanding_q, outstanding_d;
  logic                    err_q, err_d;
  logic [1:0]              count_q, count_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [mcl_width_p-1:0]  mem_q [2];
  logic [mcl_width_p-1:0]  mem_d [2];

  logic buf_full;
  logic buf_empty;
  logic credit_ok;
  logic req_r;
  logic accept;
  logic deq;
  logic resp;

  assign buf_full  = (count_q == 2'd2);
  assign buf_empty = (count_q == 2'd0);

  // Both the link-side credit pool and the receive FIFO must be able to absorb one more response.
  assign credit_ok = (outstanding_q < max_cnt_lp) & (outstanding_q < bus_if.rcv_vacancy_i);

  assign req_r  = reset_n_i & credit_ok & ~buf_full & (state_q == ST_RUN) & ~bus_if.fence_i;
  assign accept = bus_if.req_v_i & req_r;
  assign deq    = ~buf_empty & bus_if.link_r_i;
  assign resp   = bus_if.resp_v_i & bus_if.resp_r_i;

  always_comb begin
    count_d  = count_q + 2'(accept) - 2'(deq);
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ deq;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = bus_if.req_data_i;
    end
  end

  // A response with nothing outstanding is an upstream protocol error; the count saturates at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    unique case ({accept, resp})
      2'b10: outstanding_d = outstanding_q + cnt_width_lp'(1);
      2'b01: begin
        if (outstanding_q == '0) begin
          err_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q - cnt_width_lp'(1);
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fence_busy_d = fence_busy_q;
    fence_done_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus_if.fence_i) begin
          state_d      = ST_DRAIN;
          fence_busy_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (buf_empty && (outstanding_q == '0)) begin
          state_d      = ST_DONE;
          fence_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d      = ST_RUN;
        fence_busy_d = 1'b0;
      end
      default: begin
        state_d      = ST_RUN;
        fence_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_RUN;
      fence_busy_q  <= 1'b0;
      fence_done_q  <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fence_busy_q  <= fence_busy_d;
      fence_done_q  <= fence_done_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus_if.req_r_o         = req_r;
  assign bus_if.link_v_o        = ~buf_empty;
  assign bus_if.link_data_o     = mem_q[rd_ptr_q];
  assign bus_if.fence_busy_o    = fence_busy_q;
  assign bus_if.fence_done_o    = fence_done_q;
  assign bus_if.out_credits_o   = max_cnt_lp - outstanding_q;
  assign bus_if.err_underflow_o = err_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    outstanding_q <= max_cnt_lp);

  a_data_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (bus_if.link_v_o && !bus_if.link_r_i) |=> (bus_if.link_v_o && $stable(bus_if.link_data_o)));

endmodule
